// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Definitions shared by the fetch stage and the controller: instruction
//   width, opcode constants, field slice helpers and the fetch FSM encoding.
//   Instruction format: [7:4] opcode, [3:0] operand (register index / imm4).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int INSTR_W  = 8;
  localparam int OPCODE_W = 4;
  localparam int OPND_W   = 4;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 8'h00;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_LDIMM = 4'hD,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_FLUSH
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

  function automatic logic [OPND_W-1:0] instr_operand(input logic [INSTR_W-1:0] instr);
    return instr[OPND_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_imem.sv
// -----------------------------------------------------------------------------
// fetch_imem
//   Instruction memory: 2**ADDR_W words of DATA_W bits, one synchronous write
//   port (program loader) and one asynchronous read port (fetch at pc).
// Ports
//   CLK    clock, rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
// -----------------------------------------------------------------------------
module fetch_imem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset on purpose; a reset of a RAM cannot map onto
  // memory macros and loaded programs must survive a core reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage: owns the instruction memory, pc and IR, applies
//   the controller's LoadIR/IncPC/LoadPC/SelPC, and fills the memory from the
//   program-load port while the core is held.
// Ports
//   CLK, CLB    clock (rising) / asynchronous active-low reset
//   LoadIR      capture imem[pc] into IR
//   IncPC       pc <= pc + 1 (wraps)
//   LoadPC      pc <= jump target (has priority over IncPC)
//   SelPC       target source: 1 = reg_data, 0 = zero-extended IR operand
//   reg_data    register-file value used as jump target
//   prog_mode   level: 1 = program load requested, 0 = run
//   prog_valid  program word valid
//   prog_data   program word
//   prog_ready  a program word is accepted this cycle
//   hold        core must stay in RESET (loading or flushing)
//   Opcode      imem[pc][7:4], combinational
//   ir_opcode   IR[7:4]
//   ir_operand  IR[3:0]
//   pc          program counter
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = fetch_unit_pkg::INSTR_W
) (
  input  logic                CLK,
  input  logic                CLB,
  input  logic                LoadIR,
  input  logic                IncPC,
  input  logic                LoadPC,
  input  logic                SelPC,
  input  logic [7:0]          reg_data,
  input  logic                prog_mode,
  input  logic                prog_valid,
  input  logic [INSTR_W-1:0]  prog_data,
  output logic                prog_ready,
  output logic                hold,
  output logic [OPCODE_W-1:0] Opcode,
  output logic [OPCODE_W-1:0] ir_opcode,
  output logic [OPND_W-1:0]   ir_operand,
  output logic [PC_W-1:0]     pc
);

  localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

  fetch_state_e       state, next_state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] imem_rdata;
  logic [PC_W-1:0]    wr_ptr;
  logic               full;
  logic               mem_we;
  logic               run_update;
  logic               load_entry;
  logic [PC_W-1:0]    jump_target;

  fetch_imem #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_imem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (imem_rdata)
  );

  // Register updates happen only in RUN with no load request pending, so a
  // prog_mode rise aborts the instruction in flight on the entry edge itself.
  assign load_entry  = (state == ST_RUN) && prog_mode;
  assign run_update  = (state == ST_RUN) && !prog_mode;
  assign hold        = (state != ST_RUN);
  assign prog_ready  = (state == ST_LOAD) && !full;
  assign mem_we      = prog_valid && prog_ready;
  assign jump_target = SelPC ? reg_data[PC_W-1:0] : PC_W'(instr_operand(ir));

  assign Opcode     = instr_opcode(imem_rdata);
  assign ir_opcode  = instr_opcode(ir);
  assign ir_operand = instr_operand(ir);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets LoadIR+LoadPC use the old IR.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN:   if (prog_mode)  next_state = ST_LOAD;
      ST_LOAD:  if (!prog_mode) next_state = ST_FLUSH;
      ST_FLUSH: next_state = ST_RUN;
      default:  next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      pc <= '0;
      ir <= INSTR_NOP;
    end else if (state == ST_FLUSH) begin
      pc <= '0;
      ir <= INSTR_NOP;
    end else if (run_update) begin
      if (LoadIR) begin
        ir <= imem_rdata;
      end
      if (LoadPC) begin
        pc <= jump_target;
      end else if (IncPC) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

  // wr_ptr wraps to 0 after the last address; full then blocks further writes.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (load_entry) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (mem_we) begin
      wr_ptr <= wr_ptr + PC_W'(1);
      if (wr_ptr == PC_MAX) begin
        full <= 1'b1;
      end
    end else if (state == ST_FLUSH) begin
      wr_ptr <= '0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit: a behavioural model checked every cycle against the
//   PC_W=8 instance, directed literal checks on both instances, and a PC_W=4
//   instance for the full-memory case.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       CLB = 1'b0;

  // PC_W = 8 instance
  logic       LoadIR = 0, IncPC = 0, LoadPC = 0, SelPC = 0;
  logic [7:0] reg_data = 8'h00;
  logic       prog_mode = 0, prog_valid = 0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_ready, hold;
  logic [3:0] Opcode, ir_opcode, ir_operand;
  logic [7:0] pc;

  // PC_W = 4 instance
  logic       s_loadir = 0, s_incpc = 0;
  logic       s_prog_mode = 0, s_prog_valid = 0;
  logic [7:0] s_prog_data = 8'h00;
  logic       s_prog_ready, s_hold;
  logic [3:0] s_opcode, s_ir_opcode, s_ir_operand;
  logic [3:0] s_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_W(8)) dut (
    .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC),
    .SelPC(SelPC), .reg_data(reg_data), .prog_mode(prog_mode),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
    .hold(hold), .Opcode(Opcode), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .pc(pc)
  );

  fetch_unit #(.PC_W(4)) dut_small (
    .CLK(CLK), .CLB(CLB), .LoadIR(s_loadir), .IncPC(s_incpc), .LoadPC(1'b0),
    .SelPC(1'b0), .reg_data(8'h00), .prog_mode(s_prog_mode),
    .prog_valid(s_prog_valid), .prog_data(s_prog_data),
    .prog_ready(s_prog_ready), .hold(s_hold), .Opcode(s_opcode),
    .ir_opcode(s_ir_opcode), .ir_operand(s_ir_operand), .pc(s_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the PC_W=8 instance ----------------
  logic [7:0] m_mem [256];
  bit         m_known [256];
  int         m_pc = 0;
  logic [7:0] m_ir = 8'h00;
  bit         m_loading = 0, m_flushing = 0, m_full = 0;
  int         m_wr = 0;

  always @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      m_pc <= 0; m_ir <= 8'h00; m_loading <= 0; m_flushing <= 0;
      m_wr <= 0; m_full <= 0;
    end else if (m_flushing) begin
      m_flushing <= 0; m_pc <= 0; m_ir <= 8'h00; m_wr <= 0;
    end else if (m_loading) begin
      if (prog_valid && !m_full) begin
        m_mem[m_wr]   <= prog_data;
        m_known[m_wr] <= 1'b1;
        m_wr          <= m_wr + 1;
        m_full        <= (m_wr == 255);
      end
      if (!prog_mode) begin
        m_loading <= 0; m_flushing <= 1;
      end
    end else if (prog_mode) begin
      m_loading <= 1; m_wr <= 0; m_full <= 0;
    end else begin
      if (LoadIR) m_ir <= m_mem[m_pc];
      if (LoadPC) m_pc <= SelPC ? int'(reg_data) : int'(m_ir[3:0]);
      else if (IncPC) m_pc <= (m_pc + 1) % 256;
    end
  end

  always @(negedge CLK) begin
    check("cyc_pc", 32'(pc), 32'(m_pc));
    check("cyc_ir", {24'h0, ir_opcode, ir_operand}, 32'(m_ir));
    check("cyc_hold", 32'(hold), 32'(m_loading || m_flushing));
    check("cyc_ready", 32'(prog_ready), 32'(m_loading && !m_full));
    if (m_known[m_pc]) check("cyc_opcode", 32'(Opcode), 32'(m_mem[m_pc][7:4]));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic li, input logic ip, input logic lp,
                      input logic sp, input logic [7:0] rd);
    LoadIR = li; IncPC = ip; LoadPC = lp; SelPC = sp; reg_data = rd;
    @(posedge CLK); #2;
    LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0;
  endtask

  task automatic put(input logic v, input logic [7:0] d);
    prog_valid = v; prog_data = d;
    @(posedge CLK); #2;
  endtask

  function automatic logic [7:0] sword(input int i);
    return 8'(i * 13 + 7);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 CLB = 1'b1;
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", {24'h0, ir_opcode, ir_operand}, 32'h00);
    check("rst_hold", 32'(hold), 32'h0);
    check("rst_ready", 32'(prog_ready), 32'h0);
    @(posedge CLK); #2;

    // Program load with gaps in prog_valid
    prog_mode = 1;
    step(0, 0, 0, 0, 8'h00);
    check("load_hold", 32'(hold), 32'h1);
    check("load_ready", 32'(prog_ready), 32'h1);
    put(1, 8'hD5); put(0, 8'h00); put(1, 8'h1A); put(0, 8'h00); put(0, 8'h00);
    LoadIR = 1; IncPC = 1;           // ignored while held
    put(1, 8'h0F); put(1, 8'h7A);
    LoadIR = 0; IncPC = 0;
    prog_valid = 0; prog_mode = 0;
    @(posedge CLK); #2;
    check("flush_hold", 32'(hold), 32'h1);
    check("flush_ready", 32'(prog_ready), 32'h0);
    @(posedge CLK); #2;
    check("run_hold", 32'(hold), 32'h0);
    check("run_pc", 32'(pc), 32'h0);
    check("run_opcode", 32'(Opcode), 32'hD);

    // Fetch
    step(1, 1, 0, 0, 8'h00);
    check("fetch_ir", {24'h0, ir_opcode, ir_operand}, 32'hD5);
    check("fetch_pc", 32'(pc), 32'h1);
    check("fetch_opcode", 32'(Opcode), 32'h1);
    step(1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h00);
    check("fetch4_ir", {24'h0, ir_opcode, ir_operand}, 32'h7A);
    check("fetch4_pc", 32'(pc), 32'h4);

    // Jumps with LoadPC and IncPC together
    step(0, 1, 1, 0, 8'h00);
    check("jmp_imm_pc", 32'(pc), 32'h0A);
    step(0, 1, 1, 1, 8'h3C);
    check("jmp_reg_pc", 32'(pc), 32'h3C);
    step(0, 0, 1, 1, 8'h00);
    step(1, 0, 1, 0, 8'h00);         // target from pre-edge IR 7A
    check("ldir_ldpc_ir", {24'h0, ir_opcode, ir_operand}, 32'hD5);
    check("ldir_ldpc_pc", 32'(pc), 32'h0A);

    // Wrap
    step(0, 0, 1, 1, 8'hFF);
    check("pre_wrap_pc", 32'(pc), 32'hFF);
    prog_valid = 1; prog_data = 8'hEE; // ignored outside LOAD
    step(0, 1, 0, 0, 8'h00);
    check("wrap_pc", 32'(pc), 32'h00);
    step(0, 1, 0, 0, 8'h00);
    prog_valid = 0;
    check("novalid_opcode", 32'(Opcode), 32'h1);

    // Asynchronous reset mid-run
    CLB = 0; #1;
    check("async_pc", 32'(pc), 32'h0);
    check("async_ir", {24'h0, ir_opcode, ir_operand}, 32'h00);
    check("async_hold", 32'(hold), 32'h0);
    #1 CLB = 1;
    step(1, 0, 0, 0, 8'h00);
    check("post_rst_ir", {24'h0, ir_opcode, ir_operand}, 32'hD5);

    // Abort: prog_mode rises on the same edge as LoadIR/IncPC
    prog_mode = 1;
    step(1, 1, 0, 0, 8'h00);
    check("abort_ir", {24'h0, ir_opcode, ir_operand}, 32'hD5);
    check("abort_pc", 32'(pc), 32'h0);
    check("abort_hold", 32'(hold), 32'h1);

    // Reset mid-LOAD keeps the word already written
    put(1, 8'h2B);
    prog_valid = 0;
    CLB = 0; #1;
    check("rst_load_hold", 32'(hold), 32'h0);
    check("rst_load_ready", 32'(prog_ready), 32'h0);
    prog_mode = 0;
    #1 CLB = 1;
    check("rst_load_opcode", 32'(Opcode), 32'h2);
    @(posedge CLK); #2;

    // Full memory on the PC_W=4 instance
    s_prog_mode = 1;
    @(posedge CLK); #2;
    for (int i = 0; i < 17; i++) begin
      check("small_ready", 32'(s_prog_ready), 32'(i < 16));
      s_prog_valid = 1; s_prog_data = sword(i);
      @(posedge CLK); #2;
    end
    s_prog_valid = 0;
    check("small_full_ready", 32'(s_prog_ready), 32'h0);
    s_prog_mode = 0;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    check("small_run_hold", 32'(s_hold), 32'h0);
    check("small_opcode0", 32'(s_opcode), 32'(sword(0) >> 4));
    for (int a = 0; a < 16; a++) begin
      s_loadir = 1; s_incpc = 1;
      @(posedge CLK); #2;
      check("small_ir", {24'h0, s_ir_opcode, s_ir_operand}, 32'(sword(a)));
      check("small_pc", 32'(s_pc), 32'((a + 1) % 16));
    end
    s_loadir = 0; s_incpc = 0;
    @(posedge CLK); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
